// File: rtl/serial_framer_pkg.sv
// Shared definitions for the serial byte framer: framing states and the default delimiter.
package serial_framer_pkg;

   localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } framer_state_e;

endpackage

// File: rtl/serial_byte_framer_sipo_shift8.sv
// 8-bit serial-in/parallel-out register; new bits enter at the LSB so the first bit ends up as the MSB.
module sipo_shift8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       shift_en,
   input  logic       clear,
   input  logic       bit_in,
   output logic [7:0] data_q
);

   logic [7:0] data_d;

   // Clear wins over shift so a lock-loss edge leaves no stale delimiter bits behind.
   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = 8'h00;
      end else if (shift_en) begin
         data_d = {data_q[6:0], bit_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 8'h00;
      end else begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/serial_byte_framer.sv
// Serial bit-stream framer: hunts for a delimiter byte, then emits fixed-length payload frames
// and tolerates up to MISS_LIMIT-1 consecutive bad delimiters before dropping lock.
module serial_byte_framer
   import serial_framer_pkg::*;
#(
   parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
   parameter int         FRAME_BYTES = 16,
   parameter int         MISS_LIMIT  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       locked,
   output logic       sync_err
);

   localparam int             BCW       = $clog2(FRAME_BYTES + 1);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
   localparam logic [2:0]     MISS_MAX  = 3'(MISS_LIMIT);

   framer_state_e  state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
   logic [2:0]     miss_cnt_q, miss_cnt_d;
   logic [3:0]     fill_cnt_q, fill_cnt_d;
   logic [7:0]     byte_out_q, byte_out_d;
   logic           byte_valid_q, byte_valid_d;
   logic           locked_q, locked_d;
   logic           sync_err_q, sync_err_d;
   logic [2:0]     miss_inc;
   logic           sr_clear;
   logic [7:0]     sr_q;
   logic [7:0]     sr_next;

   sipo_shift8 u_sipo (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (bit_valid),
      .clear    (sr_clear),
      .bit_in   (bit_in),
      .data_q   (sr_q)
   );

   // The byte as it will look once the bit sampled on this edge has been shifted in.
   assign sr_next = {sr_q[6:0], bit_in};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      fill_cnt_d   = fill_cnt_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      locked_d     = locked_q;
      sync_err_d   = 1'b0;
      sr_clear     = 1'b0;
      miss_inc     = miss_cnt_q + 3'd1;

      if (bit_valid) begin
         case (state_q)
            HUNT: begin
               if (fill_cnt_q != 4'd8) begin
                  fill_cnt_d = fill_cnt_q + 4'd1;
               end
               // fill_cnt_q >= 7 means this edge completes at least 8 bits since entering HUNT.
               if (fill_cnt_q >= 4'd7 && sr_next == SYNC_WORD) begin
                  state_d    = PAYLOAD;
                  locked_d   = 1'b1;
                  bit_cnt_d  = 3'd0;
                  byte_cnt_d = '0;
                  miss_cnt_d = 3'd0;
                  fill_cnt_d = 4'd0;
               end
            end

            PAYLOAD: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_out_d   = sr_next;
                  byte_valid_d = 1'b1;
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_d = '0;
                     state_d    = CHECK;
                  end else begin
                     byte_cnt_d = byte_cnt_q + BCW'(1);
                  end
               end
            end

            CHECK: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (sr_next == SYNC_WORD) begin
                     state_d    = PAYLOAD;
                     miss_cnt_d = 3'd0;
                  end else begin
                     sync_err_d = 1'b1;
                     if (miss_inc == MISS_MAX) begin
                        state_d    = HUNT;
                        locked_d   = 1'b0;
                        miss_cnt_d = 3'd0;
                        fill_cnt_d = 4'd0;
                        sr_clear   = 1'b1;
                     end else begin
                        state_d    = PAYLOAD;
                        miss_cnt_d = miss_inc;
                     end
                  end
               end
            end

            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= '0;
         miss_cnt_q   <= 3'd0;
         fill_cnt_q   <= 4'd0;
         byte_out_q   <= 8'h00;
         byte_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         fill_cnt_q   <= fill_cnt_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         locked_q     <= locked_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign locked     = locked_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_serial_byte_framer.sv
// Scoreboard bench for serial_byte_framer: the driver queues each payload byte it sends while
// locked, and a negedge monitor pops and compares data and latency whenever byte_valid is seen.
module tb_serial_byte_framer;
   import serial_framer_pkg::*;

   localparam int FRAME_BYTES = 16;
   localparam int MISS_LIMIT  = 2;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       bit_in    = 1'b0;
   logic       bit_valid = 1'b0;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       locked;
   logic       sync_err;

   typedef struct {
      logic [7:0] data;
      int         edgeIdx;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   cyc         = 0;
   int   compared    = 0;
   int   mismatched  = 0;
   int   syncErrSeen = 0;
   int   syncErrExp  = 0;
   bit   gapMode     = 1'b0;

   serial_byte_framer #(
      .SYNC_WORD   (SYNC_WORD_DEFAULT),
      .FRAME_BYTES (FRAME_BYTES),
      .MISS_LIMIT  (MISS_LIMIT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: every byte_valid must match the oldest queued byte, one edge after its 8th bit.
   always @(negedge clk) begin
      if (rst_n && sync_err) syncErrSeen++;
      if (byte_valid) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_byte: got %0h expected no byte_valid (t=%0t)", byte_out, $time);
         end else begin
            monE = expQ.pop_front();
            checkOutput("byte_data", byte_out, monE.data);
            checkOutput("byte_latency", cyc, monE.edgeIdx);
         end
      end
   end

   task automatic applyStimulus(input logic b);
      if (gapMode) begin
         for (int g = 0; g < 20 && $urandom_range(99) >= 30; g++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
         end
      end
      @(negedge clk);
      bit_in    = b;
      bit_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end
   endtask

   task automatic sendByte(input logic [7:0] v, input bit expectOut);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(v[i]);
      end
      if (expectOut) expQ.push_back('{data: v, edgeIdx: cyc + 1});
   endtask

   task automatic sendFrame();
      for (int i = 0; i < FRAME_BYTES; i++) begin
         sendByte(8'($urandom), 1'b1);
      end
   endtask

   task automatic badDelimiter(input logic expLocked, input string tag);
      sendByte(8'h5A, 1'b0);
      idle(1);
      syncErrExp++;
      checkOutput({tag, "_sync_err"}, sync_err, 1'b1);
      checkOutput({tag, "_locked"}, locked, expLocked);
   endtask

   initial begin
      logic [7:0] huntBits;
      logic [7:0] firstByte;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_byte_out", byte_out, 8'h00);
      checkOutput("reset_byte_valid", byte_valid, 1'b0);
      checkOutput("reset_locked", locked, 1'b0);
      checkOutput("reset_sync_err", sync_err, 1'b0);
      rst_n = 1'b1;

      // Basic lock and a counting frame.
      sendByte(8'hA5, 1'b0);
      idle(1);
      checkOutput("locked_after_sync", locked, 1'b1);
      for (int i = 0; i < FRAME_BYTES; i++) sendByte(8'(i), 1'b1);
      sendByte(8'hA5, 1'b0);
      idle(1);
      checkOutput("good_delim_no_err", sync_err, 1'b0);
      checkOutput("good_delim_locked", locked, 1'b1);
      sendFrame();

      // Single miss flywheels; a good delimiter then clears the miss count.
      badDelimiter(1'b1, "miss1");
      sendFrame();
      sendByte(8'hA5, 1'b0);
      sendFrame();
      badDelimiter(1'b1, "miss_after_clear");
      sendFrame();
      sendByte(8'hA5, 1'b0);

      // Two consecutive misses drop lock.
      sendFrame();
      badDelimiter(1'b1, "miss_a");
      sendFrame();
      badDelimiter(1'b0, "miss_b");

      // Stale 5A bits plus 0101 would read A5 if the HUNT fill gate were ignored.
      huntBits = 8'h05;
      for (int i = 3; i >= 0; i--) applyStimulus(huntBits[i]);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0);
      idle(1);
      checkOutput("no_false_lock", locked, 1'b0);

      // Sliding alignment: five ones then A5 then payload.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1);
      huntBits = 8'hA5;
      for (int i = 7; i >= 1; i--) applyStimulus(huntBits[i]);
      idle(1);
      checkOutput("slide_not_yet_locked", locked, 1'b0);
      applyStimulus(huntBits[0]);
      idle(1);
      checkOutput("slide_locked", locked, 1'b1);
      firstByte = {1'b1, 7'($urandom)};
      sendByte(firstByte, 1'b1);
      for (int i = 1; i < FRAME_BYTES; i++) sendByte(8'($urandom), 1'b1);
      sendByte(8'hA5, 1'b0);

      // Sparse bit_valid must produce the same bytes.
      gapMode = 1'b1;
      sendFrame();
      sendByte(8'hA5, 1'b0);
      gapMode = 1'b0;
      idle(1);
      checkOutput("gap_no_err", sync_err, 1'b0);
      checkOutput("gap_locked", locked, 1'b1);

      // Reset mid byte 3: outputs clear asynchronously and a relock is required.
      for (int i = 0; i < 3; i++) sendByte(8'($urandom), 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'($urandom));
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_byte_out", byte_out, 8'h00);
      checkOutput("async_rst_byte_valid", byte_valid, 1'b0);
      checkOutput("async_rst_locked", locked, 1'b0);
      checkOutput("async_rst_sync_err", sync_err, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sendByte(8'h00, 1'b0);
      sendByte(8'h3C, 1'b0);
      idle(1);
      checkOutput("post_reset_unlocked", locked, 1'b0);
      sendByte(8'hA5, 1'b0);
      idle(1);
      checkOutput("relocked", locked, 1'b1);
      sendFrame();
      sendByte(8'hA5, 1'b0);
      idle(4);

      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("sync_err_count", syncErrSeen, syncErrExp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
